// File: rtl/matrix_arb_pkg.sv
// Shared constants for the matrix job arbiter: FSM state encoding and size limits.
// Used by matrix_job_arbiter and rr_arbiter.
package matrix_arb_pkg;

    localparam int SIZE_W      = 8;
    localparam int MAX_DIM_DEF = 32;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_COMPLETE = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant and wraps.
// The parent registers the result.
module rr_arbiter #(
    parameter int  REQ_COUNT = 4,
    localparam int GW        = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic [REQ_COUNT-1:0] grant,
    output logic [GW-1:0]        grant_idx,
    output logic                 valid
);

    localparam int SW = GW + 1;

    logic [SW-1:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        pos       = '0;
        for (int i = 1; i <= REQ_COUNT; i++) begin
            pos = {1'b0, last_grant} + SW'(i);
            if (pos >= SW'(REQ_COUNT)) begin
                pos = pos - SW'(REQ_COUNT);
            end
            if (!valid && req[pos[GW-1:0]]) begin
                valid                 = 1'b1;
                grant[pos[GW-1:0]]    = 1'b1;
                grant_idx             = pos[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/matrix_job_arbiter.sv
// Round-robin job scheduler in front of the shared matrix sequencer.
// Optional cycle counter output o_job_cycles when MATRIX_ARB_PERF_EN is defined.
//
// state      | meaning
// IDLE       | waiting for a request, arbitrates and latches sizes
// ISSUE      | start asserted, sequencer given a cycle to leave idle
// RUN        | start held until the sequencer drops o_finished
// DRAIN      | start released, waiting for o_finished to return
// COMPLETE   | done (and err for rejected jobs) pulse, rotate priority
module matrix_job_arbiter
    import matrix_arb_pkg::*;
#(
    parameter int  REQ_COUNT = 4,
    parameter int  MAX_DIM   = MAX_DIM_DEF,
    localparam int GW        = $clog2(REQ_COUNT)
) (
    input  logic                        CLOCK_25,
    input  logic                        rst,
    input  logic [REQ_COUNT-1:0]        i_req,
    input  logic [SIZE_W*REQ_COUNT-1:0] i_size_column,
    input  logic [SIZE_W*REQ_COUNT-1:0] i_size_row,
    output logic [REQ_COUNT-1:0]        o_ack,
    output logic [REQ_COUNT-1:0]        o_done,
    output logic                        o_err,
    output logic                        o_start,
    output logic [SIZE_W-1:0]           o_size_column,
    output logic [SIZE_W-1:0]           o_size_row,
    input  logic                        i_finished,
    output logic                        o_busy,
    output logic [GW-1:0]               o_grant_id
`ifdef MATRIX_ARB_PERF_EN
    ,output logic [15:0]                o_job_cycles
`endif
);

    localparam logic [SIZE_W-1:0] MAX_DIM_W = SIZE_W'(MAX_DIM);

    logic [2:0]           state;
    logic [GW-1:0]        last_grant;
    logic                 rejected;
    logic [REQ_COUNT-1:0] arb_grant;
    logic [GW-1:0]        arb_idx;
    logic                 arb_valid;
    logic [SIZE_W-1:0]    win_col;
    logic [SIZE_W-1:0]    win_row;
    logic                 win_bad;

    rr_arbiter #(.REQ_COUNT(REQ_COUNT)) u_rr (
        .req        (i_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .valid      (arb_valid)
    );

    always_comb begin
        win_col = '0;
        win_row = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (arb_grant[k]) begin
                win_col = i_size_column[k*SIZE_W +: SIZE_W];
                win_row = i_size_row[k*SIZE_W +: SIZE_W];
            end
        end
        win_bad = (win_col == '0) || (win_col > MAX_DIM_W) ||
                  (win_row == '0) || (win_row > MAX_DIM_W);
    end

    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            state         <= S_IDLE;
            o_start       <= 1'b0;
            o_size_column <= '0;
            o_size_row    <= '0;
            o_ack         <= '0;
            o_done        <= '0;
            o_err         <= 1'b0;
            o_busy        <= 1'b0;
            o_grant_id    <= '0;
            last_grant    <= GW'(REQ_COUNT - 1);
            rejected      <= 1'b0;
        end else begin
            o_ack  <= '0;
            o_done <= '0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        o_ack         <= arb_grant;
                        o_size_column <= win_col;
                        o_size_row    <= win_row;
                        o_grant_id    <= arb_idx;
                        rejected      <= win_bad;
                        o_busy        <= 1'b1;
                        state         <= win_bad ? S_COMPLETE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_start <= 1'b1;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    // o_finished low means the sequencer has finished and parked
                    if (!i_finished) begin
                        o_start <= 1'b0;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_finished) begin
                        state <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    o_done[o_grant_id] <= 1'b1;
                    o_err              <= rejected;
                    last_grant         <= o_grant_id;
                    o_busy             <= 1'b0;
                    state              <= S_IDLE;
                end
                default: begin
                    o_start <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MATRIX_ARB_PERF_EN
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            o_job_cycles <= '0;
        end else if (state == S_IDLE && arb_valid) begin
            o_job_cycles <= '0;
        end else if ((state == S_ISSUE || state == S_RUN || state == S_DRAIN) &&
                     o_job_cycles != 16'hFFFF) begin
            o_job_cycles <= o_job_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_job_arbiter.sv
// Self-checking bench for matrix_job_arbiter with a behavioural sequencer model.
// Exercises o_job_cycles as well when MATRIX_ARB_PERF_EN is defined.
module tb_matrix_job_arbiter;

    localparam int RC = 4;

    logic            CLOCK_25 = 1'b0;
    logic            rst;
    logic [RC-1:0]   i_req;
    logic [8*RC-1:0] i_size_column;
    logic [8*RC-1:0] i_size_row;
    logic [RC-1:0]   o_ack;
    logic [RC-1:0]   o_done;
    logic            o_err;
    logic            o_start;
    logic [7:0]      o_size_column;
    logic [7:0]      o_size_row;
    logic            i_finished = 1'b1;
    logic            o_busy;
    logic [1:0]      o_grant_id;
`ifdef MATRIX_ARB_PERF_EN
    logic [15:0]     o_job_cycles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int run_len = 3;
    int ret_len = 1;
    int seq_cnt = 0;
    bit seq_active = 1'b0;
    int model_last = RC - 1;

    always #20 CLOCK_25 = ~CLOCK_25;

    matrix_job_arbiter #(.REQ_COUNT(RC), .MAX_DIM(32)) dut (
        .CLOCK_25      (CLOCK_25),
        .rst           (rst),
        .i_req         (i_req),
        .i_size_column (i_size_column),
        .i_size_row    (i_size_row),
        .o_ack         (o_ack),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_start       (o_start),
        .o_size_column (o_size_column),
        .o_size_row    (o_size_row),
        .i_finished    (i_finished),
        .o_busy        (o_busy),
        .o_grant_id    (o_grant_id)
`ifdef MATRIX_ARB_PERF_EN
        ,.o_job_cycles (o_job_cycles)
`endif
    );

    // Sequencer: finished drops run_len cycles after it sees start, returns ret_len later.
    always @(negedge CLOCK_25) begin
        if (rst) begin
            seq_active = 1'b0;
            seq_cnt    = 0;
            i_finished = 1'b1;
        end else if (!seq_active) begin
            if (o_start === 1'b1) begin
                seq_active = 1'b1;
                seq_cnt    = 0;
            end
        end else begin
            seq_cnt++;
            if (seq_cnt == run_len) i_finished = 1'b0;
            if (seq_cnt == run_len + ret_len) begin
                i_finished = 1'b1;
                seq_active = 1'b0;
            end
        end
    end

    function automatic int rr_pick(logic [RC-1:0] req, int last);
        for (int i = 1; i <= RC; i++) begin
            if (req[(last + i) % RC]) return (last + i) % RC;
        end
        return -1;
    endfunction

    function automatic bit bad_size(logic [7:0] col, logic [7:0] row);
        return (col == 0) || (col > 32) || (row == 0) || (row > 32);
    endfunction

    function automatic logic [7:0] rand_size();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'($urandom_range(33, 255));
        return 8'($urandom_range(1, 32));
    endfunction

    task automatic tick();
        @(negedge CLOCK_25);
    endtask

    task automatic set_size(int k, logic [7:0] col, logic [7:0] row);
        i_size_column[8*k +: 8] = col;
        i_size_row[8*k +: 8]    = row;
    endtask

    task automatic wait_ack(output logic [RC-1:0] ack_v, output bit ok);
        ok    = 1'b0;
        ack_v = '0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge CLOCK_25);
            if (o_ack !== '0) begin
                ok    = 1'b1;
                ack_v = o_ack;
            end
        end
    endtask

    // Observes from the ack cycle up to and including the done pulse.
    task automatic wait_done(output logic [RC-1:0] done_v, output logic err,
                             output int start_cycles, output int extra_acks,
                             output int lat, output bit ok);
        ok = 1'b0; done_v = '0; err = 1'b0;
        start_cycles = 0; extra_acks = 0; lat = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge CLOCK_25);
            lat++;
            if (o_start === 1'b1) start_cycles++;
            if (o_ack !== '0) extra_acks++;
            if (o_done !== '0) begin
                ok     = 1'b1;
                done_v = o_done;
                err    = o_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = '0; i_size_column = '0; i_size_row = '0;
        repeat (3) tick();
        n_cmp++; if (o_ack !== '0)         begin n_fail++; $display("FAIL reset_ack got=%b want=0", o_ack); end
        n_cmp++; if (o_done !== '0)        begin n_fail++; $display("FAIL reset_done got=%b want=0", o_done); end
        n_cmp++; if (o_err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got=%b want=0", o_err); end
        n_cmp++; if (o_start !== 1'b0)     begin n_fail++; $display("FAIL reset_start got=%b want=0", o_start); end
        n_cmp++; if (o_size_column !== '0) begin n_fail++; $display("FAIL reset_col got=%0d want=0", o_size_column); end
        n_cmp++; if (o_size_row !== '0)    begin n_fail++; $display("FAIL reset_row got=%0d want=0", o_size_row); end
        n_cmp++; if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        n_cmp++; if (o_grant_id !== '0)    begin n_fail++; $display("FAIL reset_gid got=%0d want=0", o_grant_id); end
`ifdef MATRIX_ARB_PERF_EN
        n_cmp++; if (o_job_cycles !== '0)  begin n_fail++; $display("FAIL reset_cycles got=%0d want=0", o_job_cycles); end
`endif
        rst = 1'b0;
        model_last = RC - 1;
        tick();
    endtask

    task automatic test_basic();
        logic [RC-1:0] ack_v, done_v; logic err; int sc, xa, lat; bit ok;
        run_len = 5; ret_len = 1;
        set_size(0, 8'd4, 8'd4);
        i_req = 4'b0001;
        wait_ack(ack_v, ok);
        i_req = '0;
        n_cmp++; if (!ok || ack_v !== 4'b0001) begin n_fail++; $display("FAIL basic_ack got=%b want=0001", ack_v); end
        n_cmp++; if (o_size_column !== 8'd4 || o_size_row !== 8'd4)
            begin n_fail++; $display("FAIL basic_size got=%0dx%0d want=4x4", o_size_column, o_size_row); end
        n_cmp++; if (o_start !== 1'b0 || o_busy !== 1'b1)
            begin n_fail++; $display("FAIL basic_ack_cycle got start=%b busy=%b want 0/1", o_start, o_busy); end
        wait_done(done_v, err, sc, xa, lat, ok);
        n_cmp++; if (!ok || done_v !== 4'b0001 || err !== 1'b0)
            begin n_fail++; $display("FAIL basic_done got=%b err=%b want=0001 err=0", done_v, err); end
        n_cmp++; if (sc !== run_len + 1) begin n_fail++; $display("FAIL basic_start_len got=%0d want=%0d", sc, run_len + 1); end
        n_cmp++; if (lat !== run_len + ret_len + 3) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, run_len + ret_len + 3); end
        n_cmp++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_at_done got=%b want=0", o_start); end
        model_last = 0;
        tick();
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got=%b want=0", o_busy); end
    endtask

    task automatic test_round_robin();
        logic [RC-1:0] ack_v, done_v, exp_v; logic err; int sc, xa, lat, exp; bit ok;
        for (int k = 0; k < RC; k++) set_size(k, 8'd4, 8'd4);
        ret_len = 1;
        run_len = $urandom_range(1, 6);
        i_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp   = rr_pick(4'b1111, model_last);
            exp_v = RC'(1) << exp;
            wait_ack(ack_v, ok);
            n_cmp++; if (!ok || ack_v !== exp_v) begin n_fail++; $display("FAIL rr_ack job=%0d got=%b want=%b", j, ack_v, exp_v); end
            wait_done(done_v, err, sc, xa, lat, ok);
            if (j == 4) i_req = '0;
            n_cmp++; if (!ok || done_v !== exp_v || err !== 1'b0 || xa !== 0)
                begin n_fail++; $display("FAIL rr_done job=%0d got=%b err=%b acks=%0d want=%b err=0 acks=0", j, done_v, err, xa, exp_v); end
            model_last = exp;
            run_len = $urandom_range(1, 6);
        end
        tick();
    endtask

    task automatic test_reject();
        logic [RC-1:0] ack_v, done_v; logic err; int sc, xa, lat; bit ok;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) set_size(2, 8'd0, 8'd4);
            else        set_size(2, 8'd4, 8'd33);
            i_req = 4'b0100;
            wait_ack(ack_v, ok);
            i_req = '0;
            n_cmp++; if (!ok || ack_v !== 4'b0100) begin n_fail++; $display("FAIL rej_ack case=%0d got=%b want=0100", c, ack_v); end
            wait_done(done_v, err, sc, xa, lat, ok);
            n_cmp++; if (!ok || done_v !== 4'b0100 || err !== 1'b1 || lat !== 1)
                begin n_fail++; $display("FAIL rej_done case=%0d got=%b err=%b lat=%0d want=0100 err=1 lat=1", c, done_v, err, lat); end
            n_cmp++; if (sc !== 0) begin n_fail++; $display("FAIL rej_start case=%0d got=%0d want=0", c, sc); end
            model_last = 2;
            tick();
        end
    endtask

    task automatic test_random();
        logic [RC-1:0] ack_v, done_v, exp_v, req; logic err; int sc, xa, lat, exp; bit ok, bad;
        logic [7:0] cols [RC]; logic [7:0] rows [RC];
        for (int j = 0; j < 14; j++) begin
            req = RC'($urandom_range(1, (1 << RC) - 1));
            for (int k = 0; k < RC; k++) begin
                cols[k] = rand_size(); rows[k] = rand_size();
                set_size(k, cols[k], rows[k]);
            end
            run_len = $urandom_range(1, 8);
            ret_len = $urandom_range(1, 3);
            exp   = rr_pick(req, model_last);
            exp_v = RC'(1) << exp;
            bad   = bad_size(cols[exp], rows[exp]);
            i_req = req;
            wait_ack(ack_v, ok);
            i_req = '0;
            n_cmp++; if (!ok || ack_v !== exp_v) begin n_fail++; $display("FAIL rnd_ack job=%0d got=%b want=%b", j, ack_v, exp_v); end
            n_cmp++; if (o_size_column !== cols[exp] || o_size_row !== rows[exp] || o_grant_id !== 2'(exp))
                begin n_fail++; $display("FAIL rnd_latch job=%0d got=%0dx%0d id=%0d want=%0dx%0d id=%0d", j, o_size_column, o_size_row, o_grant_id, cols[exp], rows[exp], exp); end
            wait_done(done_v, err, sc, xa, lat, ok);
            n_cmp++; if (!ok || done_v !== exp_v || err !== bad)
                begin n_fail++; $display("FAIL rnd_done job=%0d got=%b err=%b want=%b err=%b", j, done_v, err, exp_v, bad); end
            n_cmp++; if (sc !== (bad ? 0 : run_len + 1) || lat !== (bad ? 1 : run_len + ret_len + 3))
                begin n_fail++; $display("FAIL rnd_timing job=%0d got start=%0d lat=%0d want start=%0d lat=%0d", j, sc, lat, bad ? 0 : run_len + 1, bad ? 1 : run_len + ret_len + 3); end
            model_last = exp;
            tick();
        end
        ret_len = 1;
    endtask

    task automatic test_size_hold();
        logic [RC-1:0] ack_v, done_v; bit ok; int bad_cycles;
        run_len = 10; ret_len = 1;
        set_size(1, 8'd10, 8'd12);
        i_req = 4'b0010;
        wait_ack(ack_v, ok);
        i_req = '0;
        bad_cycles = 0; done_v = '0;
        for (int c = 0; c < 200 && done_v === '0; c++) begin
            i_size_column = $urandom(); i_size_row = $urandom();
            tick();
            if (o_size_column !== 8'd10 || o_size_row !== 8'd12) bad_cycles++;
            if (o_done !== '0) done_v = o_done;
        end
        n_cmp++; if (!ok || done_v !== 4'b0010) begin n_fail++; $display("FAIL hold_done got=%b want=0010", done_v); end
        n_cmp++; if (bad_cycles !== 0) begin n_fail++; $display("FAIL hold_size changed_cycles=%0d want=0", bad_cycles); end
        model_last = 1;
        tick();
    endtask

    task automatic test_reset_mid_job();
        logic [RC-1:0] ack_v, done_v; logic err; int sc, xa, lat, stray; bit ok;
        run_len = 30; ret_len = 1;
        set_size(1, 8'd8, 8'd8);
        i_req = 4'b0010;
        wait_ack(ack_v, ok);
        i_req = '0;
        repeat (5) tick();
        n_cmp++; if (o_start !== 1'b1) begin n_fail++; $display("FAIL midrst_in_run got start=%b want=1", o_start); end
        rst = 1'b1;
        tick();
        n_cmp++; if (o_start !== 1'b0 || o_busy !== 1'b0 || o_done !== '0 || o_ack !== '0 ||
                     o_size_column !== '0 || o_size_row !== '0 || o_grant_id !== '0 || o_err !== 1'b0)
            begin n_fail++; $display("FAIL midrst_outputs got start=%b busy=%b done=%b col=%0d gid=%0d want all 0", o_start, o_busy, o_done, o_size_column, o_grant_id); end
        tick();
        rst = 1'b0;
        model_last = RC - 1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_done !== '0 || o_busy !== 1'b0) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d stray cycles want=0", stray); end
        run_len = 4;
        set_size(3, 8'd2, 8'd3); set_size(0, 8'd5, 8'd5);
        i_req = 4'b1000;
        wait_ack(ack_v, ok);
        i_req = '0;
        n_cmp++; if (!ok || ack_v !== 4'b1000) begin n_fail++; $display("FAIL midrst_grant3 got=%b want=1000", ack_v); end
        wait_done(done_v, err, sc, xa, lat, ok);
        model_last = 3;
        i_req = 4'b0001;
        wait_ack(ack_v, ok);
        i_req = '0;
        n_cmp++; if (!ok || ack_v !== 4'b0001) begin n_fail++; $display("FAIL midrst_grant0 got=%b want=0001", ack_v); end
        wait_done(done_v, err, sc, xa, lat, ok);
        n_cmp++; if (!ok || done_v !== 4'b0001) begin n_fail++; $display("FAIL midrst_done0 got=%b want=0001", done_v); end
        model_last = 0;
        tick();
    endtask

`ifdef MATRIX_ARB_PERF_EN
    task automatic test_perf();
        logic [RC-1:0] ack_v, done_v; logic err; int sc, xa, lat; bit ok;
        run_len = 40; ret_len = 1;
        set_size(0, 8'd4, 8'd4);
        i_req = 4'b0001;
        wait_ack(ack_v, ok);
        i_req = '0;
        n_cmp++; if (o_job_cycles !== 16'd0) begin n_fail++; $display("FAIL perf_clear got=%0d want=0", o_job_cycles); end
        wait_done(done_v, err, sc, xa, lat, ok);
        // ISSUE is one cycle, RUN lasts run_len+1, DRAIN lasts ret_len
        n_cmp++; if (!ok || o_job_cycles !== 16'(1 + run_len + 1 + ret_len))
            begin n_fail++; $display("FAIL perf_count got=%0d want=%0d", o_job_cycles, 1 + run_len + 1 + ret_len); end
        model_last = 0;
        tick();
        set_size(2, 8'd0, 8'd4);
        i_req = 4'b0100;
        wait_ack(ack_v, ok);
        i_req = '0;
        wait_done(done_v, err, sc, xa, lat, ok);
        n_cmp++; if (!ok || o_job_cycles !== 16'd0) begin n_fail++; $display("FAIL perf_reject got=%0d want=0", o_job_cycles); end
        model_last = 2;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; i_req = '0; i_size_column = '0; i_size_row = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_reject();
        test_random();
        test_size_hold();
        test_reset_mid_job();
`ifdef MATRIX_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_job_arbiter.md
# matrix_job_arbiter

Schedules matrix jobs from several requesters onto the single shared matrix sequencer and its core array. It round-robin arbitrates pending requests, checks the requested dimensions, then drives the sequencer's start/size inputs. It holds the start level through the sequencer's finish handshake and returns a per-requester done pulse. It sits between the SERV-side job ports and the sequencer's `start`/`size_column`/`size_row`/`o_finished` pins.

## Interface
- `REQ_COUNT`, 4: number of requesters (2..8).
- `MAX_DIM`, 32: largest legal row or column size; the sequencer addresses are 5 bits.
- `GW`, `$clog2(REQ_COUNT)`: grant index width (derived, not overridden).

- `CLOCK_25`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  REQ_COUNT  level job request, one bit per requester.
- `i_size_column`  in  8*REQ_COUNT  column size per requester; requester k uses bits [8k+7:8k].
- `i_size_row`  in  8*REQ_COUNT  row size per requester, same packing.
- `o_ack`  out  REQ_COUNT  one-cycle pulse: job latched.
- `o_done`  out  REQ_COUNT  one-cycle pulse: job complete or rejected.
- `o_err`  out  1  pulse coincident with `o_done`: job rejected for bad size.
- `o_start`  out  1  to sequencer `start`.
- `o_size_column`  out  8  to sequencer; held stable for the whole job.
- `o_size_row`  out  8  to sequencer; held stable for the whole job.
- `i_finished`  in  1  from sequencer `o_finished`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_grant_id`  out  GW  index of the current or last job owner.

## Operation
- States: IDLE, ISSUE, RUN, DRAIN, COMPLETE. All are registered and all outputs are registered.
- IDLE
  - If any `i_req` bit is set, pick the winner round-robin. The search starts at `last_grant+1` and wraps at REQ_COUNT-1 → 0.
  - Latch the winner's sizes into `o_size_*` and set `o_grant_id`.
  - Pulse `o_ack[winner]`.
  - If either size is 0 or greater than MAX_DIM, go to COMPLETE with the error flag set. Otherwise go to ISSUE.
- ISSUE: `o_start`=1. Go to RUN unconditionally; this gives the sequencer one cycle to leave idle.
- RUN: `o_start`=1. When `i_finished`==0 (sequencer done and parked), go to DRAIN.
- DRAIN: `o_start`=0. When `i_finished`==1 (sequencer back in idle), go to COMPLETE.
- COMPLETE
  - Pulse `o_done[grant_id]`; pulse `o_err` if the job was rejected.
  - Set `last_grant` = `grant_id`, then go to IDLE.
- Requesters drop `i_req` no later than the cycle after `o_ack`. A request still high when the arbiter returns to IDLE counts as a new job.
- `i_req` and size inputs are ignored outside IDLE. Only one job is ever in flight.
- Size compares are unsigned 8-bit.

## Timing
- Reset values:
  - state IDLE, `o_start`=0, `o_size_*`=0.
  - `o_ack`=0, `o_done`=0, `o_err`=0, `o_busy`=0.
  - `o_grant_id`=0; `last_grant`=REQ_COUNT-1, so requester 0 wins first.
- Request to ack: request sampled at edge N; `o_ack` and latched sizes are visible after edge N.
- Valid job: `o_start` rises the cycle after `o_ack` and stays high until the first cycle `i_finished`=0 is sampled. It falls at the next edge.
- Rejected job: `o_done`+`o_err` come one cycle after `o_ack`; `o_start` never rises.
- `o_done` comes one cycle after `i_finished` returns to 1 in DRAIN. At least one idle cycle separates `o_done` from the next `o_ack`.
- Reset asserted mid-job: the job is abandoned, with no `o_done`. The sequencer shares `rst`.

## Configuration
- `MATRIX_ARB_PERF_EN` defined:
  - Adds output `o_job_cycles[15:0]`, which counts cycles spent in ISSUE+RUN+DRAIN for the last valid job. It saturates at 16'hFFFF.
  - It is cleared at `o_ack` and is valid from the `o_done` pulse until the next `o_ack`. Reset value is 0.
  - Rejected jobs leave it at 0.
- Not defined: no port, no counter logic.

## Structure
- Shared package `matrix_arb_pkg`: state encoding constants, `MAX_DIM` default, size-width constant (8).
- Sub-module `rr_arbiter`: pure request vector plus `last_grant` → one-hot grant and index. It is combinational, and the parent registers its output.

## Test plan
- Reset, then `i_req`=4'b0001 with sizes 4×4 → `o_ack[0]`; `o_start` high for ISSUE+RUN; sequencer model drops finished → `o_start` low; finished high → `o_done[0]`, `o_err`=0.
- Requests 4'b1111 held continuously, 4×4 each → grants in order 0,1,2,3,0, with exactly one job in flight.
- Requester 2 with column size 0, and again with row size 33 → `o_ack[2]`, then `o_done[2]`+`o_err` next cycle; `o_start` stays 0.
- Reset asserted during RUN → next cycle all outputs at reset values and no `o_done` pulse; the following request from 3 is granted before 0.
- Requester 1 changes `i_size_column` mid-job → `o_size_column` unchanged until `o_done`.
- With `MATRIX_ARB_PERF_EN`, model the sequencer as taking 40 cycles from start to finished=0 and 1 cycle to return → `o_job_cycles` equals ISSUE+RUN+DRAIN count (43).
